// File: rtl/udma_ts_chan_sched.sv
// Round-robin scheduler sharing the uDMA timestamp ingest path between N_CH sources.
// Each winner's channel ID and payload are registered, held, and announced by a level toggle on ts_valid_o.
module udma_ts_chan_sched #(
  parameter int N_CH          = 4,
  parameter int TS_DATA_WIDTH = 28,
  parameter int TS_CHID_WIDTH = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_CH-1:0]               cfg_ch_en_i,
  input  logic                          cfg_drop_clr_i,
  input  logic [N_CH-1:0]               req_valid_i,
  input  logic [N_CH*TS_DATA_WIDTH-1:0] req_data_i,
  output logic [N_CH-1:0]               req_ready_o,
  output logic                          ts_valid_o,
  output logic [TS_CHID_WIDTH-1:0]      ts_chid_o,
  output logic [TS_DATA_WIDTH-1:0]      ts_data_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int POP_W  = $clog2(N_CH + 1);
  localparam int SUM_W  = CNT_WIDTH + POP_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_q;
  logic [HCNT_W-1:0]         hold_cnt_q;
  logic                      ts_valid_q;
  logic [TS_CHID_WIDTH-1:0]  ts_chid_q;
  logic [TS_DATA_WIDTH-1:0]  ts_data_q;
  logic [CNT_WIDTH-1:0]      drop_cnt_q;

  logic [N_CH-1:0]           eligible;
  logic [N_CH-1:0]           drop_mask;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_fire;
  int                        cand_int;
  logic [IDX_W-1:0]          cand;
  logic [POP_W-1:0]          drop_pop;
  logic [SUM_W-1:0]          drop_sum;

  assign eligible  = req_valid_i & cfg_ch_en_i;
  assign drop_mask = req_valid_i & ~cfg_ch_en_i;

  // Round-robin search starting just after the last winner, wrapping modulo N_CH.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand        = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand_int = int'(last_q) + k;
      if (cand_int >= N_CH) cand_int = cand_int - N_CH;
      cand = IDX_W'(cand_int);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < N_CH; i++) drop_pop = drop_pop + POP_W'(drop_mask[i]);
    drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_pop);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments; the reset branch is asynchronous.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant_found) state_d = S_HOLD;
      S_HOLD: if (hold_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: drops are acknowledged in any state, grants only in IDLE.
  always_comb begin
    busy_o      = (state_q == S_HOLD);
    grant_fire  = (state_q == S_IDLE) && grant_found;
    req_ready_o = drop_mask;
    if (grant_fire) req_ready_o = req_ready_o | (N_CH'(1) << grant_idx);
    if (rst_i)      req_ready_o = '0;
  end

  // Sample registers and hold counter: all update together on the accepting edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_valid_q <= 1'b0;
      ts_chid_q  <= '0;
      ts_data_q  <= '0;
      last_q     <= IDX_W'(N_CH - 1);
      hold_cnt_q <= '0;
    end else if (grant_fire) begin
      ts_valid_q <= ~ts_valid_q;
      ts_chid_q  <= TS_CHID_WIDTH'(grant_idx);
      ts_data_q  <= req_data_i[grant_idx*TS_DATA_WIDTH +: TS_DATA_WIDTH];
      last_q     <= grant_idx;
      hold_cnt_q <= HCNT_W'(HOLD_CYCLES - 1);
    end else if (state_q == S_HOLD && hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end

  // Saturating drop counter; a clear discards the same cycle's drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             drop_cnt_q <= '0;
    else if (cfg_drop_clr_i)               drop_cnt_q <= '0;
    else if (drop_sum > SUM_W'(CNT_MAX))   drop_cnt_q <= CNT_MAX;
    else                                   drop_cnt_q <= drop_sum[CNT_WIDTH-1:0];
  end

  assign ts_valid_o = ts_valid_q;
  assign ts_chid_o  = ts_chid_q;
  assign ts_data_o  = ts_data_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_udma_ts_chan_sched.sv
// Self-checking bench for udma_ts_chan_sched: grant vector table, scoreboard of expected samples,
// and hand-written sequences for hold timing, drops, saturation and mid-HOLD reset.
module tb_udma_ts_chan_sched;

  localparam int N_CH = 4;
  localparam int DW   = 28;
  localparam int CW   = 4;
  localparam int HOLD = 8;
  localparam int CNTW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH-1:0]      en;
  logic                 clr;
  logic [N_CH-1:0]      valid;
  logic [DW-1:0]        data_arr [N_CH];
  logic [N_CH*DW-1:0]   req_data;
  logic [N_CH-1:0]      ready;
  logic                 ts_valid;
  logic [CW-1:0]        ts_chid;
  logic [DW-1:0]        ts_data;
  logic                 busy;
  logic [CNTW-1:0]      drop_cnt;

  typedef struct {
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] valid;
    logic [N_CH-1:0] exp_ready;
    int              exp_grant;   // -1: no grant expected
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] chid;
    logic [DW-1:0] data;
  } sample_t;

  vec_t    vecs [8];
  sample_t exp_q [$];
  int      n_vec = 0;
  int      n_err = 0;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N_CH; i++) req_data[i*DW +: DW] = data_arr[i];

  udma_ts_chan_sched #(
    .N_CH(N_CH), .TS_DATA_WIDTH(DW), .TS_CHID_WIDTH(CW), .HOLD_CYCLES(HOLD), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_ch_en_i   (en),
    .cfg_drop_clr_i(clr),
    .req_valid_i   (valid),
    .req_data_i    (req_data),
    .req_ready_o   (ready),
    .ts_valid_o    (ts_valid),
    .ts_chid_o     (ts_chid),
    .ts_data_o     (ts_data),
    .busy_o        (busy),
    .drop_cnt_o    (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int ch);
    return DW'(32'h0A00000 + ch * 32'h11111);
  endfunction

  // Scoreboard monitor: samples 2 time units after each rising edge.
  int   mon_cyc = 0;
  int   last_tog = -1;
  bit   spacing_en = 1'b0;
  logic prev_v = 1'b0;
  always @(posedge clk) begin
    sample_t s;
    #2;
    mon_cyc++;
    if (rst) begin
      prev_v   = ts_valid;
      last_tog = -1;
    end else if (ts_valid !== prev_v) begin
      prev_v = ts_valid;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_toggle: chid %0d data 0x%0h with no sample expected (t=%0t)",
                 ts_chid, ts_data, $time);
      end else begin
        s = exp_q.pop_front();
        check("ts_chid", 64'(ts_chid), 64'(s.chid));
        check("ts_data", 64'(ts_data), 64'(s.data));
      end
      if (spacing_en && last_tog >= 0) check("toggle_spacing", 64'(mon_cyc - last_tog), 64'(HOLD + 1));
      last_tog = mon_cyc;
    end
  end

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    sample_t s;
    s.chid = CW'(ch);
    s.data = d;
    exp_q.push_back(s);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    en    = 4'($urandom);
    valid = 4'($urandom);
    for (int i = 0; i < N_CH; i++) data_arr[i] = DW'($urandom);

    vecs[0] = '{4'b1111, 4'b1011, 4'b1000,  3};
    vecs[1] = '{4'b1111, 4'b1011, 4'b0001,  0};
    vecs[2] = '{4'b1111, 4'b1011, 4'b0010,  1};
    vecs[3] = '{4'b0111, 4'b1100, 4'b1100,  2};
    vecs[4] = '{4'b1110, 4'b0001, 4'b0001, -1};
    vecs[5] = '{4'b1111, 4'b0110, 4'b0010,  1};
    vecs[6] = '{4'b1111, 4'b1111, 4'b0100,  2};
    vecs[7] = '{4'b0000, 4'b0000, 4'b0000, -1};

    // Reset with random inputs: everything held at zero.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready",    64'(ready),    64'd0);
    check("rst_ts_valid", 64'(ts_valid), 64'd0);
    check("rst_ts_chid",  64'(ts_chid),  64'd0);
    check("rst_ts_data",  64'(ts_data),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    valid = '0;
    en    = 4'b1111;
    rst   = 1'b0;
    @(negedge clk);
    #1 check("idle_busy", 64'(busy), 64'd0);

    // Single request on channel 2, then HOLD timing.
    @(negedge clk);
    valid       = 4'b0100;
    data_arr[2] = 28'h0ABCDEF;
    push_exp(2, 28'h0ABCDEF);
    #1 check("single_ready", 64'(ready), 64'b0100);
    @(negedge clk);
    #1;
    check("single_ts_valid",  64'(ts_valid), 64'd1);
    check("hold_no_grant",    64'(ready),    64'd0);
    valid = '0;
    for (int c = 0; c < HOLD; c++) begin
      check("hold_busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
    end
    check("hold_end_busy", 64'(busy), 64'd0);

    // Table-driven grant / drop vectors (round-robin pointer starts after channel 2).
    for (int v = 0; v < 8; v++) begin
      wait_idle();
      @(negedge clk);
      en    = vecs[v].en;
      valid = vecs[v].valid;
      for (int i = 0; i < N_CH; i++) data_arr[i] = data_of(i) + DW'(v);
      if (vecs[v].exp_grant >= 0) push_exp(vecs[v].exp_grant, data_of(vecs[v].exp_grant) + DW'(v));
      #1 check($sformatf("vec%0d_ready", v), 64'(ready), 64'(vecs[v].exp_ready));
      @(negedge clk);
      valid = '0;
    end
    wait_idle();
    #1 check("vec_drop_cnt", 64'(drop_cnt), 64'd2);

    // All channels continuously valid after reset: order 0,1,2,3,..., toggles 9 cycles apart.
    do_reset();
    en = 4'b1111;
    for (int i = 0; i < N_CH; i++) data_arr[i] = data_of(i);
    for (int n = 0; n < 8; n++) push_exp(n % N_CH, data_of(n % N_CH));
    spacing_en = 1'b1;
    valid = 4'b1111;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("rr_queue_drained", 64'(exp_q.size()), 64'd0);
    valid      = '0;
    spacing_en = 1'b0;
    wait_idle();

    // Disabled channel 1 valid for 3 cycles: acknowledged, dropped, counted.
    @(negedge clk);
    en    = 4'b1101;
    valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1 check("drop_ready", 64'(ready), 64'b0010);
      @(negedge clk);
    end
    valid = '0;
    #1 check("drop_cnt3", 64'(drop_cnt), 64'd3);
    @(negedge clk);
    valid = 4'b0010;
    clr   = 1'b1;
    @(negedge clk);
    valid = '0;
    clr   = 1'b0;
    #1 check("drop_clear_wins", 64'(drop_cnt), 64'd0);

    // Channel 3 granted, reset pulsed in HOLD cycle 4, then ch0 and ch3 compete.
    @(negedge clk);
    en    = 4'b1111;
    valid = 4'b1000;
    for (int i = 0; i < N_CH; i++) data_arr[i] = data_of(i) + DW'(32'h40);
    push_exp(3, data_of(3) + DW'(32'h40));
    @(negedge clk);
    valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midhold_rst_ts_valid", 64'(ts_valid), 64'd0);
    check("midhold_rst_ts_chid",  64'(ts_chid),  64'd0);
    check("midhold_rst_ts_data",  64'(ts_data),  64'd0);
    check("midhold_rst_busy",     64'(busy),     64'd0);
    @(negedge clk);
    rst   = 1'b0;
    valid = 4'b1001;
    push_exp(0, data_of(0) + DW'(32'h40));
    #1 check("post_rst_ready", 64'(ready), 64'b0001);
    @(negedge clk);
    valid = '0;
    #1 check("post_rst_ts_valid", 64'(ts_valid), 64'd1);
    wait_idle();

    // Two disabled channels valid for 200 cycles: counter saturates.
    @(negedge clk);
    en    = 4'b0011;
    valid = 4'b1100;
    #1 check("sat_ready", 64'(ready), 64'b1100);
    repeat (100) @(negedge clk);
    #1 check("sat_cnt_mid", 64'(drop_cnt), 64'd200);
    repeat (100) @(negedge clk);
    #1 check("sat_cnt_full", 64'(drop_cnt), 64'd255);
    valid = '0;
    repeat (2) @(negedge clk);
    #1 check("sat_cnt_stays", 64'(drop_cnt), 64'd255);

    repeat (12) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
